// File: rtl/rom_read_sequencer.sv
// Sequential ROM dump engine: walks addresses 0..LAST_ADDRESS, strobes the ROM
// with cs_n/oe_n, captures each byte and hands it off under valid/ready.
module rom_read_sequencer #(
  parameter int ACCESS_CYCLES = 8,
  parameter int LAST_ADDRESS  = 511
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic [8:0] rom_address,
  output logic       rom_cs_n,
  output logic       rom_oe_n,
  input  logic [7:0] rom_data,
  output logic [7:0] data_out,
  output logic [8:0] data_addr,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] LAST_WAIT = 8'(ACCESS_CYCLES - 1);
  localparam logic [8:0] LAST_ADDR = 9'(LAST_ADDRESS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_HANDOFF,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic [8:0] r_rom_address;
  logic       r_cs_n;
  logic       r_oe_n;
  logic [7:0] r_data_out;
  logic [8:0] r_data_addr;
  logic       r_data_valid;
  logic       r_busy;
  logic       r_done;
  logic       w_active;

  assign w_active = (r_state == S_SETUP) || (r_state == S_WAIT) ||
                    (r_state == S_HANDOFF);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_rom_address <= '0;
      r_cs_n        <= 1'b1;
      r_oe_n        <= 1'b1;
      r_data_out    <= '0;
      r_data_addr   <= '0;
      r_data_valid  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else if (abort && w_active) begin
      // Abort releases the ROM bus but leaves the address where it stopped.
      r_state      <= S_IDLE;
      r_cs_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state       <= S_SETUP;
            r_rom_address <= '0;
            r_done        <= 1'b0;
            r_busy        <= 1'b1;
            r_cs_n        <= 1'b0;
            r_oe_n        <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= '0;
          r_oe_n     <= 1'b0;
        end
        S_WAIT: begin
          if (r_wait_cnt == LAST_WAIT) begin
            r_state      <= S_HANDOFF;
            r_data_out   <= rom_data;
            r_data_addr  <= r_rom_address;
            r_data_valid <= 1'b1;
            r_oe_n       <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_HANDOFF: begin
          if (data_ready) begin
            r_data_valid <= 1'b0;
            if (r_rom_address == LAST_ADDR) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_cs_n  <= 1'b1;
            end else begin
              r_state       <= S_SETUP;
              r_rom_address <= r_rom_address + 9'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cs_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_address = r_rom_address;
  assign rom_cs_n    = r_cs_n;
  assign rom_oe_n    = r_oe_n;
  assign data_out    = r_data_out;
  assign data_addr   = r_data_addr;
  assign data_valid  = r_data_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Directed bench for rom_read_sequencer: full dump, back-pressure, abort,
// capture timing, reset during handoff, and a single-address dump.
module tb_rom_read_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       data_ready = 1'b1;
  logic [8:0] rom_address;
  logic       rom_cs_n, rom_oe_n;
  logic [7:0] rom_data;
  logic [7:0] data_out;
  logic [8:0] data_addr;
  logic       data_valid, busy, done;
  logic       ovr_en = 1'b0;
  logic [7:0] ovr_val = 8'h00;

  logic       start0 = 1'b0;
  logic       abort0 = 1'b0;
  logic [8:0] rom_address0;
  logic       rom_cs_n0, rom_oe_n0;
  logic [7:0] rom_data0;
  logic [7:0] data_out0;
  logic [8:0] data_addr0;
  logic       data_valid0, busy0, done0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rom_data  = ovr_en ? ovr_val : (rom_address[7:0] ^ 8'hA5);
  assign rom_data0 = rom_address0[7:0] ^ 8'hA5;

  rom_read_sequencer #(.ACCESS_CYCLES(8), .LAST_ADDRESS(511)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rom_address(rom_address), .rom_cs_n(rom_cs_n), .rom_oe_n(rom_oe_n),
    .rom_data(rom_data), .data_out(data_out), .data_addr(data_addr),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy), .done(done)
  );

  rom_read_sequencer #(.ACCESS_CYCLES(3), .LAST_ADDRESS(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0),
    .rom_address(rom_address0), .rom_cs_n(rom_cs_n0), .rom_oe_n(rom_oe_n0),
    .rom_data(rom_data0), .data_out(data_out0), .data_addr(data_addr0),
    .data_valid(data_valid0), .data_ready(data_ready), .busy(busy0), .done(done0)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string pfx);
    check({pfx, "_addr"},  32'(rom_address), 0);
    check({pfx, "_cs_n"},  32'(rom_cs_n), 1);
    check({pfx, "_oe_n"},  32'(rom_oe_n), 1);
    check({pfx, "_dout"},  32'(data_out), 0);
    check({pfx, "_daddr"}, 32'(data_addr), 0);
    check({pfx, "_valid"}, 32'(data_valid), 0);
    check({pfx, "_busy"},  32'(busy), 0);
    check({pfx, "_done"},  32'(done), 0);
  endtask

  initial begin
    int cyc;
    int idx;
    int oe_cnt;
    int viol;
    int nvalid;

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    check_idle_reset("rst");
    reset = 1'b1;
    tick();

    // Full dump, ready tied high; a stray start mid-dump must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("setup_busy", 32'(busy), 1);
    check("setup_cs_n", 32'(rom_cs_n), 0);
    check("setup_oe_n", 32'(rom_oe_n), 1);
    check("setup_addr", 32'(rom_address), 0);
    cyc = 0; idx = 0; oe_cnt = 0; viol = 0;
    while (!done && cyc < 6000) begin
      tick();
      cyc++;
      start = (cyc == 100);
      if (!rom_oe_n && rom_cs_n) viol++;
      if (!rom_oe_n) oe_cnt++;
      if (data_valid) begin
        if (idx == 0) check("first_latency", 32'(cyc), 9);
        check("oe_low_cycles", 32'(oe_cnt), 8);
        check("dump_addr", 32'(data_addr), 32'(idx));
        check("dump_data", 32'(data_out), 32'((idx & 8'hFF) ^ 8'hA5));
        idx++;
        oe_cnt = 0;
      end
    end
    start = 1'b0;
    check("done_cycle", 32'(cyc), 5120);
    check("byte_count", 32'(idx), 512);
    check("done_addr", 32'(rom_address), 511);
    check("done_busy", 32'(busy), 0);
    check("done_cs_n", 32'(rom_cs_n), 1);
    check("oe_without_cs", 32'(viol), 0);

    // Restart from DONE, back-pressure at address 3
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_clear", 32'(done), 0);
    cyc = 0;
    while (!(data_valid && data_addr == 9'd3) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("reach_addr3", 32'(data_addr), 3);
    data_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_valid", 32'(data_valid), 1);
      check("hold_daddr", 32'(data_addr), 3);
      check("hold_data", 32'(data_out), 32'(8'h03 ^ 8'hA5));
      check("hold_romaddr", 32'(rom_address), 3);
    end
    data_ready = 1'b1;
    tick();
    check("resume_addr", 32'(rom_address), 4);
    check("resume_valid", 32'(data_valid), 0);

    // Abort during WAIT at address 10
    cyc = 0;
    while (!(rom_address == 9'd10 && !rom_oe_n) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("reach_wait10", 32'(rom_oe_n), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_cs_n", 32'(rom_cs_n), 1);
    check("abort_oe_n", 32'(rom_oe_n), 1);
    check("abort_valid", 32'(data_valid), 0);
    check("abort_addr", 32'(rom_address), 10);
    check("abort_busy", 32'(busy), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_ignored", 32'(rom_address), 10);

    // Start and abort together in IDLE: start wins, dump restarts at 0
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("restart_busy", 32'(busy), 1);
    check("restart_addr", 32'(rom_address), 0);
    check("restart_cs_n", 32'(rom_cs_n), 0);

    // Data changes late in WAIT; only the value at the final WAIT edge counts
    cyc = 0; oe_cnt = 0;
    while (!data_valid && cyc < 50) begin
      tick();
      cyc++;
      if (!rom_oe_n) begin
        oe_cnt++;
        if (oe_cnt == 7) begin ovr_en = 1'b1; ovr_val = 8'h11; end
        if (oe_cnt == 8) ovr_val = 8'h3C;
      end
    end
    check("late_capture", 32'(data_out), 32'h3C);
    check("late_oe_cycles", 32'(oe_cnt), 8);
    check("late_daddr", 32'(data_addr), 0);
    ovr_en = 1'b0;

    // Reset in HANDOFF dominates start and abort
    reset = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    check_idle_reset("handoff_rst");
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 0);

    // Single-address dump (LAST_ADDRESS=0, ACCESS_CYCLES=3)
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 0; nvalid = 0;
    while (!done0 && cyc < 50) begin
      tick();
      cyc++;
      if (data_valid0) begin
        nvalid++;
        check("one_daddr", 32'(data_addr0), 0);
        check("one_data", 32'(data_out0), 32'hA5);
      end
    end
    check("one_done_cycle", 32'(cyc), 5);
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    tick();
    check("one_done_hold", 32'(done0), 1);
    check("one_addr", 32'(rom_address0), 0);
    check("one_count", 32'(nvalid), 1);
    check("one_cs_n", 32'(rom_cs_n0), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
